decoder_pipelined_scan: RTL and testbench
=========================================

DECODER_PIPELINED_SCAN -- requirements
Module: decoder_pipelined_scan

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 4: binary index width, legal range 1..8.
REQ-002 SHALL have derived constant OUT_WIDTH, value 1<<IN_WIDTH: decoded word width, not overridable.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  global decode enable; also aborts a running scan.
REQ-006 SHALL have port mode  input  2  selects 00 one-hot, 01 thermometer, 10 one-cold, 11 scan.
REQ-007 SHALL have port binary_in  input  IN_WIDTH  index to decode.
REQ-008 SHALL have port in_valid  input  1  binary_in/mode/enable valid.
REQ-009 SHALL have port in_ready  output  1  input accepted when in_valid && in_ready.
REQ-010 SHALL have port scan_start  input  1  single-cycle request to start a scan.
REQ-011 SHALL have port scan_dwell  input  8  idle cycles inserted between scan beats.
REQ-012 SHALL have port decoder_out  output  OUT_WIDTH  registered decoded word.
REQ-013 SHALL have port out_valid  output  1  decoder_out holds an unconsumed beat.
REQ-014 SHALL have port out_ready  input  1  downstream consumes the beat when out_valid && out_ready.
REQ-015 SHALL have port scan_busy  output  1  scan FSM not IDLE.
REQ-016 SHALL have port scan_done  output  1  one-cycle pulse after the final scan beat is accepted.

Function
REQ-017 SHALL decode index k as follows: one-hot sets only bit k; thermometer sets bits 0..k; one-cold clears only bit k.
REQ-018 SHALL, with enable low at acceptance, produce the inactive word: all-zero for one-hot and thermometer, all-ones for one-cold.
REQ-019 SHALL register each accepted input into decoder_out with out_valid high on the next cycle, giving 1-cycle latency.
REQ-020 SHALL drive in_ready = (FSM IDLE) && (mode != 11) && (!out_valid || out_ready), giving full throughput of one beat per cycle.
REQ-021 SHALL hold decoder_out and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL ignore in_valid while mode == 11.
REQ-023 SHALL implement scan FSM states IDLE, EMIT, WAIT_ACC and DWELL.
REQ-024 SHALL leave IDLE for EMIT only when scan_start && mode == 11 && enable, sampling scan_dwell there and zeroing the scan index.
REQ-025 SHALL, in EMIT, load the one-hot word of the scan index into the output register (when out_valid is low or being accepted) and move to WAIT_ACC.
REQ-026 SHALL, in WAIT_ACC, on acceptance go to DWELL if the sampled dwell > 0, else straight to EMIT with index+1.
REQ-027 SHALL hold DWELL for exactly the sampled number of cycles, then go to EMIT with index+1.
REQ-028 SHALL, on acceptance of index OUT_WIDTH-1, pulse scan_done one cycle and return to IDLE; the index never wraps.
REQ-029 SHALL, when enable goes low in any non-IDLE state, return to IDLE next cycle without scan_done; an already-valid beat stays valid until accepted.
REQ-030 SHALL ignore mode changes and scan_start while scan_busy is high.

Reset
REQ-031 SHALL, while reset_n is low, force decoder_out=0, out_valid=0, scan_busy=0, scan_done=0, in_ready=0 and FSM=IDLE.
REQ-032 SHALL accept input on the first rising edge after reset_n rises; reset mid-scan discards the pending beat.

Structure
REQ-033 SHALL place the mode encoding enum and the FSM state enum in shared package decoder_pkg.
REQ-034 SHALL put the combinational index/mode/enable -> word function in sub-module decoder_core, shared by the input and scan paths.

Verification (IN_WIDTH=4)
REQ-035 SHALL cover: mode 00, enable 1, binary_in 5, out_ready 1 -> 16'h0020 with out_valid one cycle later.
REQ-036 SHALL cover: mode 01, binary_in 3 -> 16'h000F; mode 10, binary_in 0 -> 16'hFFFE; mode 10, enable 0 -> 16'hFFFF.
REQ-037 SHALL cover: out_ready low for 3 cycles with in_valid high -> in_ready low, decoder_out held, no beat lost or duplicated.
REQ-038 SHALL cover: mode 11, scan_dwell 2, out_ready 1 -> 16 beats 16'h0001..16'h8000 spaced 4 cycles apart, then one scan_done pulse.
REQ-039 SHALL cover: enable dropped after beat 16'h0008 -> FSM IDLE next cycle, no scan_done, pending beat still delivered.
REQ-040 SHALL cover: reset_n asserted mid-scan -> all outputs 0 asynchronously, then normal decode after release.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the pipelined decoder: output mode encoding and scan FSM states.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT  = 2'b00,
    MODE_THERM   = 2'b01,
    MODE_ONECOLD = 2'b10,
    MODE_SCAN    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EMIT     = 2'b01,
    ST_WAIT_ACC = 2'b10,
    ST_DWELL    = 2'b11
  } scan_state_e;

  localparam int DWELL_WIDTH = 8;

endpackage

// File: rtl/decoder_core.sv
// Combinational index/mode/enable -> decoded word; shared by the input and scan paths.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH = 4
) (
  input  logic [IN_WIDTH-1:0]       index,
  input  mode_e                     mode,
  input  logic                      enable,
  output logic [(1<<IN_WIDTH)-1:0]  word
);

  localparam int OUT_WIDTH = 1 << IN_WIDTH;

  logic [OUT_WIDTH-1:0] onehot_s;
  logic [OUT_WIDTH-1:0] therm_s;

  // Thermometer is the one-hot bit plus every bit below it.
  always_comb begin
    onehot_s = OUT_WIDTH'(1'b1) << index;
    therm_s  = onehot_s | (onehot_s - OUT_WIDTH'(1'b1));
  end

  // Mode select; a disabled decode yields the inactive level of the chosen code.
  always_comb begin
    word = {OUT_WIDTH{1'b0}};
    case (mode)
      MODE_ONEHOT:  word = enable ? onehot_s : {OUT_WIDTH{1'b0}};
      MODE_THERM:   word = enable ? therm_s  : {OUT_WIDTH{1'b0}};
      MODE_ONECOLD: word = enable ? ~onehot_s : {OUT_WIDTH{1'b1}};
      default:      word = {OUT_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/decoder_pipelined_scan.sv
// Registered binary decoder with valid/ready output stage and a one-hot scan sequencer.
module decoder_pipelined_scan
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [IN_WIDTH-1:0]       binary_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      scan_start,
  input  logic [DWELL_WIDTH-1:0]    scan_dwell,
  output logic [(1<<IN_WIDTH)-1:0]  decoder_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      scan_busy,
  output logic                      scan_done
);

  localparam int OUT_WIDTH = 1 << IN_WIDTH;

  scan_state_e              state_r, state_s;
  logic [IN_WIDTH-1:0]      scan_idx_r, scan_idx_s;
  logic [DWELL_WIDTH-1:0]   dwell_r, dwell_s;
  logic [DWELL_WIDTH-1:0]   dwell_cnt_r, dwell_cnt_s;
  logic [OUT_WIDTH-1:0]     out_word_r;
  logic                     out_valid_r;
  logic                     scan_done_r, scan_done_s;
  logic                     scan_load_s;
  logic                     out_free_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic [IN_WIDTH-1:0]      core_idx_s;
  mode_e                    core_mode_s;
  logic                     core_en_s;
  logic [OUT_WIDTH-1:0]     core_word_s;
  mode_e                    mode_s;

  assign mode_s     = mode_e'(mode);
  assign out_free_s = !out_valid_r || out_ready;
  // reset_n gates in_ready so the port reads 0 throughout reset.
  assign in_ready_s = reset_n && (state_r == ST_IDLE) && (mode_s != MODE_SCAN) && out_free_s;
  assign accept_s   = in_valid && in_ready_s;

  // Core input mux: the scan path owns the core only while emitting.
  always_comb begin
    core_idx_s  = binary_in;
    core_mode_s = mode_s;
    core_en_s   = enable;
    if (state_r == ST_EMIT) begin
      core_idx_s  = scan_idx_r;
      core_mode_s = MODE_ONEHOT;
      core_en_s   = 1'b1;
    end else begin
      core_idx_s  = binary_in;
      core_mode_s = mode_s;
      core_en_s   = enable;
    end
  end

  decoder_core #(.IN_WIDTH(IN_WIDTH)) u_core (
    .index  (core_idx_s),
    .mode   (core_mode_s),
    .enable (core_en_s),
    .word   (core_word_s)
  );

  // Scan FSM next-state logic; dropping enable aborts from any busy state.
  always_comb begin
    state_s     = state_r;
    scan_idx_s  = scan_idx_r;
    dwell_s     = dwell_r;
    dwell_cnt_s = dwell_cnt_r;
    scan_done_s = 1'b0;
    scan_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (scan_start && (mode_s == MODE_SCAN) && enable) begin
          state_s    = ST_EMIT;
          dwell_s    = scan_dwell;
          scan_idx_s = {IN_WIDTH{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (out_free_s) begin
          scan_load_s = 1'b1;
          state_s     = ST_WAIT_ACC;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_WAIT_ACC: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (out_valid_r && out_ready) begin
          if (scan_idx_r == {IN_WIDTH{1'b1}}) begin
            scan_done_s = 1'b1;
            state_s     = ST_IDLE;
          end else if (dwell_r != {DWELL_WIDTH{1'b0}}) begin
            dwell_cnt_s = dwell_r;
            state_s     = ST_DWELL;
          end else begin
            scan_idx_s = scan_idx_r + IN_WIDTH'(1'b1);
            state_s    = ST_EMIT;
          end
        end else begin
          state_s = ST_WAIT_ACC;
        end
      end
      ST_DWELL: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (dwell_cnt_r <= DWELL_WIDTH'(1'b1)) begin
          scan_idx_s = scan_idx_r + IN_WIDTH'(1'b1);
          state_s    = ST_EMIT;
        end else begin
          dwell_cnt_s = dwell_cnt_r - DWELL_WIDTH'(1'b1);
          state_s     = ST_DWELL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Scan FSM state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      scan_idx_r  <= {IN_WIDTH{1'b0}};
      dwell_r     <= {DWELL_WIDTH{1'b0}};
      dwell_cnt_r <= {DWELL_WIDTH{1'b0}};
      scan_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      scan_idx_r  <= scan_idx_s;
      dwell_r     <= dwell_s;
      dwell_cnt_r <= dwell_cnt_s;
      scan_done_r <= scan_done_s;
    end
  end

  // Output stage: loads only when empty or draining, so a stalled beat is never overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_word_r  <= {OUT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (scan_load_s || accept_s) begin
      out_word_r  <= core_word_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready    = in_ready_s;
  assign decoder_out = out_word_r;
  assign out_valid   = out_valid_r;
  assign scan_busy   = (state_r != ST_IDLE);
  assign scan_done   = scan_done_r;

endmodule

// File: tb/tb_decoder_pipelined_scan.sv
// Directed and randomized checks of decoder_pipelined_scan against a queue-based reference.
module tb_decoder_pipelined_scan;

  localparam int IN_WIDTH  = 4;
  localparam int OUT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic [1:0]           mode;
  logic [IN_WIDTH-1:0]  binary_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 scan_start;
  logic [7:0]           scan_dwell;
  logic [OUT_WIDTH-1:0] decoder_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 scan_busy;
  logic                 scan_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder_pipelined_scan #(.IN_WIDTH(IN_WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .binary_in   (binary_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .scan_start  (scan_start),
    .scan_dwell  (scan_dwell),
    .decoder_out (decoder_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .scan_busy   (scan_busy),
    .scan_done   (scan_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the code definitions, using plain integer arithmetic.
  function automatic logic [15:0] ref_word(input int m, input bit en, input int k);
    int v;
    if (m == 2)       v = en ? (65535 - (1 << k)) : 65535;
    else if (!en)     v = 0;
    else if (m == 0)  v = 1 << k;
    else              v = (1 << (k + 1)) - 1;
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_q[$];
  int nb, last, ndone, extra;
  bit hit, pending, exp_ready;

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode = 2'b00; binary_in = 4'd0; in_valid = 1'b0;
    scan_start = 1'b0; scan_dwell = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out", decoder_out, 16'h0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", scan_busy, 1'b0);
    check("rst_done", scan_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);

    // Basic decodes at full throughput.
    @(negedge clk);
    reset_n = 1'b1; mode = 2'b00; enable = 1'b1; binary_in = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("first_in_ready", in_ready, 1'b1);
    tick();
    check("onehot5", decoder_out, 16'h0020);
    check("onehot5_valid", out_valid, 1'b1);
    mode = 2'b01; binary_in = 4'd3;
    tick();
    check("therm3", decoder_out, 16'h000F);
    mode = 2'b10; binary_in = 4'd0;
    tick();
    check("onecold0", decoder_out, 16'hFFFE);
    enable = 1'b0;
    tick();
    check("onecold_dis", decoder_out, 16'hFFFF);
    check("onecold_dis_valid", out_valid, 1'b1);

    // Backpressure: held beat, no acceptance while stalled.
    enable = 1'b1; mode = 2'b00; binary_in = 4'd7; out_ready = 1'b0;
    #1 check("bp_in_ready0", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_word", decoder_out, 16'hFFFF);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1'b1);
    tick();
    check("bp_next_word", decoder_out, 16'h0080);
    check("bp_next_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 1'b0);

    // Full scan with dwell 2.
    mode = 2'b11; scan_dwell = 8'd2; in_valid = 1'b1;
    #1 check("scan_mode_in_ready", in_ready, 1'b0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("scan_busy", scan_busy, 1'b1);
    nb = 0; last = 0; ndone = 0;
    for (int i = 0; i < 200 && ndone == 0; i++) begin
      if (out_valid) begin
        check("scan_word", decoder_out, 32'(1 << nb));
        if (nb > 0) check("scan_gap", i - last, 4);
        last = i;
        nb++;
      end
      if (scan_done) begin
        ndone++;
        check("scan_done_timing", i, last + 1);
      end
      tick();
    end
    check("scan_beats", nb, 16);
    check("scan_done_cnt", ndone, 1);
    check("scan_idle", scan_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (scan_done) ndone++;
      if (out_valid) nb++;
      tick();
    end
    check("scan_done_once", ndone, 1);
    check("scan_no_extra", nb, 16);

    // Scan aborted by enable while beat 0x0008 is pending.
    in_valid = 1'b0; scan_dwell = 8'd0; out_ready = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    nb = 0; hit = 1'b0; ndone = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      out_ready = 1'b0;
      #1;
      if (scan_done) ndone++;
      if (out_valid) begin
        if (decoder_out == 16'h0008) hit = 1'b1;
        else begin
          check("abort_word", decoder_out, 32'(1 << nb));
          nb++;
          out_ready = 1'b1;
        end
      end
    end
    check("abort_reached", hit, 1'b1);
    check("abort_prior_beats", nb, 3);
    enable = 1'b0;
    tick();
    check("abort_idle", scan_busy, 1'b0);
    check("abort_pending_valid", out_valid, 1'b1);
    check("abort_pending_word", decoder_out, 16'h0008);
    out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (scan_done) ndone++;
      if (out_valid) extra++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_no_more_beats", extra, 0);

    // Reset asserted mid-scan.
    enable = 1'b1; scan_dwell = 8'd3; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (6) tick();
    check("rst_mid_busy_before", scan_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_out", decoder_out, 16'h0000);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", scan_busy, 1'b0);
    check("rst_mid_done", scan_done, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b0);
    mode = 2'b00; binary_in = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_word", decoder_out, 16'h0200);
    check("post_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    check("post_rst_drain", out_valid, 1'b0);

    // Randomized traffic against the queue model.
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      mode      = 2'($urandom_range(0, 2));
      enable    = ($urandom_range(0, 3) != 0);
      binary_in = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      pending   = (exp_q.size() != 0);
      exp_ready = !pending || out_ready;
      check("rnd_valid", out_valid, pending);
      if (pending) check("rnd_word", decoder_out, exp_q[0]);
      check("rnd_in_ready", in_ready, exp_ready);
      if (pending && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) exp_q.push_back(ref_word(int'(mode), enable, int'(binary_in)));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rnd_drained", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
